// File: rtl/vadd_seq_pipe.sv
// Multi-cycle signed vector adder/subtractor: LANES lanes of W bits, LPC lanes per clock.
// Optional build macro VADD_SAT_EN clamps overflowing lanes instead of wrapping them.
module vadd_seq_pipe #(
  parameter int LANES = 16,
  parameter int W     = 16,
  parameter int LPC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_sub,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               busy,
  output logic               done,
  output logic [LANES*W-1:0] sum_v,
  output logic [LANES-1:0]   ovf_lane,
  output logic               ovf_any
);

  localparam int BEATS = LANES / LPC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (LANES * W > 1) ? $clog2(LANES * W) : 1;
  localparam int OW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  generate
    if ((LANES % LPC) != 0) begin : g_lpc_check
      $error("vadd_seq_pipe: LANES must be a multiple of LPC");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  logic [BW-1:0]      beat_r;
  logic [LANES*W-1:0] a_r;
  logic [LANES*W-1:0] b_r;
  logic               sub_r;

  logic [AW-1:0]      base_s;
  logic [OW-1:0]      obase_s;
  logic [LPC*W-1:0]   slice_a_s;
  logic [LPC*W-1:0]   slice_b_s;
  logic [LPC*W-1:0]   slice_sum_s;
  logic [LPC-1:0]     slice_ovf_s;
  logic [W:0]         lane_res_s;

  // One lane: {overflow, result}; lanes never share a carry.
  function automatic logic [W:0] lane_op(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         sub);
    logic [W-1:0] bp;
    logic [W-1:0] s;
    logic         ovf;
    bp  = sub ? ~b : b;
    s   = a + bp + {{(W-1){1'b0}}, sub};
    ovf = (a[W-1] == bp[W-1]) && (s[W-1] != a[W-1]);
`ifdef VADD_SAT_EN
    if (ovf) begin
      s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      s = s;
    end
`endif
    return {ovf, s};
  endfunction

  // Select the current beat's lanes from the latched operands and compute them.
  always_comb begin
    base_s      = AW'(int'(beat_r) * LPC * W);
    obase_s     = OW'(int'(beat_r) * LPC);
    slice_a_s   = a_r[base_s +: LPC*W];
    slice_b_s   = b_r[base_s +: LPC*W];
    slice_sum_s = '0;
    slice_ovf_s = '0;
    lane_res_s  = '0;
    for (int j = 0; j < LPC; j++) begin
      lane_res_s = lane_op(slice_a_s[j*W +: W], slice_b_s[j*W +: W], sub_r);
      slice_sum_s[j*W +: W] = lane_res_s[W-1:0];
      slice_ovf_s[j]        = lane_res_s[W];
    end
  end

  // Control FSM, operand latches and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      beat_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sub_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_v    <= '0;
      ovf_lane <= '0;
      ovf_any  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r      <= in_a;
            b_r      <= in_b;
            sub_r    <= op_sub;
            sum_v    <= '0;
            ovf_lane <= '0;
            ovf_any  <= 1'b0;
            beat_r   <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          sum_v[base_s +: LPC*W]  <= slice_sum_s;
          ovf_lane[obase_s +: LPC] <= slice_ovf_s;
          if (beat_r == LAST_BEAT) begin
            // Earlier beats' flags are already in ovf_lane; fold in the final slice.
            ovf_any <= (|ovf_lane) | (|slice_ovf_s);
            done    <= 1'b1;
            busy    <= 1'b0;
            beat_r  <= '0;
            state_r <= IDLE;
          end else begin
            done    <= 1'b0;
            beat_r  <= beat_r + BW'(1);
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
